// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg : opcode, immediate-select and FSM encodings for RV32I fetch
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_stage_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Shared with the immediate extender
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_imm_sel_decode.sv
// ---------------------------------------------------------------------------
// imm_sel_decode : opcode -> immediate type select and illegal-opcode flag
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imm_sel_decode
  import fetch_stage_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] imm_sel_o,
  output logic       illegal_o
);

  always_comb begin
    imm_sel_o = IMM_I;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_IMM, OP_LOAD, OP_JALR: imm_sel_o = IMM_I;
      OP_STORE:                 imm_sel_o = IMM_S;
      OP_JAL:                   imm_sel_o = IMM_J;
      OP_BRANCH:                imm_sel_o = IMM_B;
      OP_LUI, OP_AUIPC:         imm_sel_o = IMM_U;
      OP_REG:                   imm_sel_o = IMM_I;
      default:                  illegal_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : RV32I instruction fetch with PC, one-entry buffer and redirects
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [24:0]     if_imm_data,
  output logic [2:0]      if_imm_sel,
  output logic            if_illegal
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ifpc_q;
  logic [31:0]     instr_q;
  logic            imem_req_q;
  logic            if_valid_q;

  logic [XLEN-1:0] w_redirect_tgt;
  logic [XLEN-1:0] w_next_seq_pc;

  assign w_redirect_tgt = redirect_pc & ~XLEN'(3);
  assign w_next_seq_pc  = ifpc_q + XLEN'(4);

  // Only one request may be outstanding: a redirect without a response parks
  // in DRAIN until the stale word has been swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ifpc_q     <= RESET_PC;
      instr_q    <= NOP_INSTR;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= REQ;
          imem_req_q <= 1'b1;
        end
        REQ: begin
          if (redirect_valid) begin
            pc_q <= w_redirect_tgt;
            if (imem_valid) begin
              state_q    <= REQ;
              imem_req_q <= 1'b1;
            end else begin
              state_q    <= DRAIN;
              imem_req_q <= 1'b0;
            end
          end else if (imem_valid) begin
            instr_q    <= imem_rdata;
            ifpc_q     <= pc_q;
            state_q    <= HOLD;
            imem_req_q <= 1'b0;
            if_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_q       <= w_redirect_tgt;
            state_q    <= REQ;
            imem_req_q <= 1'b1;
            if_valid_q <= 1'b0;
          end else if (if_ready) begin
            pc_q       <= w_next_seq_pc;
            state_q    <= REQ;
            imem_req_q <= 1'b1;
            if_valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (redirect_valid) begin
            pc_q <= w_redirect_tgt;
          end
          if (imem_valid) begin
            state_q    <= REQ;
            imem_req_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_pc       = ifpc_q;
  assign if_instr    = instr_q;
  assign if_imm_data = instr_q[31:7];

  imm_sel_decode u_imm_sel_decode (
    .opcode_i  (instr_q[6:0]),
    .imm_sel_o (if_imm_sel),
    .illegal_o (if_illegal)
  );

endmodule

`default_nettype wire
